// File: rtl/rx_deserializer.sv
// Oversampled UART-style receiver: deframes WIDTH-bit packets (LSB first, odd parity in the MSB),
// delivers the parity-stripped word with a one-cycle flag and keeps saturating error statistics.
module rx_deserializer #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_data_flag,
  output logic             parity_error,
  output logic             framing_error,
  output logic [7:0]       error_count,
  output logic             rx_busy
);

  localparam int unsigned IdxW     = $clog2(WIDTH);
  localparam logic [3:0]  HalfLast = 4'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  BitLast  = 4'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  LastBit  = 7'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [3:0]       clk_cnt_q;
  logic [6:0]       bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             s_in;
  logic [7:0]       err_inc;

  assign s_in = sync_q[1];

  always_comb begin
    err_inc = error_count;
    if (error_count != 8'hFF) begin
      err_inc = error_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= 2'b11;
      state_q       <= StIdle;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data       <= '0;
      rx_data_flag  <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      error_count   <= '0;
      rx_busy       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], rx_in};
      rx_data_flag  <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!s_in) begin
            state_q   <= StStart;
            clk_cnt_q <= '0;
            rx_busy   <= 1'b1;
          end
        end
        StStart: begin
          if (clk_cnt_q == HalfLast) begin
            // A start bit that is already high again by mid-bit is treated as line noise.
            if (s_in) begin
              state_q <= StIdle;
              rx_busy <= 1'b0;
            end else begin
              state_q   <= StData;
              clk_cnt_q <= '0;
              bit_cnt_q <= '0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 4'd1;
          end
        end
        StData: begin
          if (clk_cnt_q == BitLast) begin
            shift_q[bit_cnt_q[IdxW-1:0]] <= s_in;
            clk_cnt_q                    <= '0;
            bit_cnt_q                    <= bit_cnt_q + 7'd1;
            if (bit_cnt_q == LastBit) begin
              state_q <= StStop;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 4'd1;
          end
        end
        StStop: begin
          if (clk_cnt_q == BitLast) begin
            clk_cnt_q <= '0;
            if (!s_in) begin
              // Framing wins over parity; the line must return high before re-arming.
              state_q       <= StWaitIdle;
              framing_error <= 1'b1;
              error_count   <= err_inc;
            end else begin
              state_q <= StIdle;
              rx_busy <= 1'b0;
              if (^shift_q) begin
                rx_data      <= shift_q[WIDTH-2:0];
                rx_data_flag <= 1'b1;
              end else begin
                parity_error <= 1'b1;
                error_count  <= err_inc;
              end
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 4'd1;
          end
        end
        StWaitIdle: begin
          if (s_in) begin
            state_q <= StIdle;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
